// File: rtl/alu_decode_stage.sv
// RV32I decode stage: turns one instruction per cycle into a registered ALU control bundle
// (operation code, operand selects, immediate, register indices) and keeps a saturating
// count of illegal instructions for debug.
module alu_decode_stage #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pause,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [31:0]      in_instr,
    input  logic [31:0]      in_pc,
    output logic             in_ready,
    output logic             out_valid,
    output logic [7:0]       out_control,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [4:0]       out_rd,
    output logic [31:0]      out_imm,
    output logic             out_use_imm,
    output logic             out_use_pc,
    output logic             out_wb_en,
    output logic             out_branch,
    output logic             out_illegal,
    output logic [31:0]      out_pc,
    output logic [CNT_W-1:0] illegal_count
);

    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;
    localparam logic [6:0] OpcBranch = 7'b1100011;

    localparam logic [6:0] F7Base = 7'b0000000;
    localparam logic [6:0] F7Alt  = 7'b0100000;

    // funct3 -> ALU code for the base (funct7 = 0) register/immediate operations
    function automatic logic [7:0] alu_map(input logic [2:0] f3);
        logic [7:0] code;
        case (f3)
            3'b000:  code = 8'h01;
            3'b001:  code = 8'h0c;
            3'b010:  code = 8'h08;
            3'b011:  code = 8'h0a;
            3'b100:  code = 8'h03;
            3'b101:  code = 8'h0d;
            3'b110:  code = 8'h04;
            default: code = 8'h05;
        endcase
        return code;
    endfunction

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i;
    logic [31:0] imm_u;
    logic [31:0] imm_b;
    logic [31:0] imm_shamt;

    logic [7:0]  dec_control;
    logic [4:0]  dec_rs1;
    logic [31:0] dec_imm;
    logic        dec_use_imm;
    logic        dec_use_pc;
    logic        dec_wb_en;
    logic        dec_branch;
    logic        dec_illegal;
    logic        accept;

    assign opcode    = in_instr[6:0];
    assign funct3    = in_instr[14:12];
    assign funct7    = in_instr[31:25];
    assign imm_i     = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_u     = {in_instr[31:12], 12'd0};
    assign imm_b     = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                        in_instr[11:8], 1'b0};
    assign imm_shamt = {27'd0, in_instr[24:20]};

    assign in_ready = !pause;
    assign accept   = in_valid & !pause & !flush;

    // Combinational decode of the incoming instruction
    always_comb begin
        dec_control = 8'h00;
        dec_rs1     = in_instr[19:15];
        dec_imm     = 32'd0;
        dec_use_imm = 1'b0;
        dec_use_pc  = 1'b0;
        dec_wb_en   = 1'b0;
        dec_branch  = 1'b0;
        dec_illegal = 1'b0;
        case (opcode)
            OpcOp: begin
                dec_wb_en = 1'b1;
                if (funct7 == F7Base) begin
                    dec_control = alu_map(funct3);
                end else if (funct7 == F7Alt && funct3 == 3'b000) begin
                    dec_control = 8'h02;
                end else if (funct7 == F7Alt && funct3 == 3'b101) begin
                    dec_control = 8'h0e;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            OpcOpImm: begin
                dec_wb_en   = 1'b1;
                dec_use_imm = 1'b1;
                dec_imm     = imm_i;
                if (funct3 == 3'b001) begin
                    dec_imm = imm_shamt;
                    if (funct7 == F7Base) dec_control = 8'h0c;
                    else                  dec_illegal = 1'b1;
                end else if (funct3 == 3'b101) begin
                    dec_imm = imm_shamt;
                    if (funct7 == F7Base)     dec_control = 8'h0d;
                    else if (funct7 == F7Alt) dec_control = 8'h0e;
                    else                      dec_illegal = 1'b1;
                end else begin
                    // No subtract-immediate: funct3 000 is always add
                    dec_control = alu_map(funct3);
                end
            end
            OpcLui: begin
                dec_control = 8'h01;
                dec_rs1     = 5'd0;
                dec_use_imm = 1'b1;
                dec_imm     = imm_u;
                dec_wb_en   = 1'b1;
            end
            OpcAuipc: begin
                dec_control = 8'h01;
                dec_use_pc  = 1'b1;
                dec_use_imm = 1'b1;
                dec_imm     = imm_u;
                dec_wb_en   = 1'b1;
            end
            OpcBranch: begin
                dec_branch = 1'b1;
                // Offset feeds the branch-target adder, not the ALU operand mux
                dec_imm    = imm_b;
                case (funct3)
                    3'b000:  dec_control = 8'h06;
                    3'b001:  dec_control = 8'h07;
                    3'b100:  dec_control = 8'h08;
                    3'b101:  dec_control = 8'h09;
                    3'b110:  dec_control = 8'h0a;
                    3'b111:  dec_control = 8'h0b;
                    default: dec_illegal = 1'b1;
                endcase
            end
            default: dec_illegal = 1'b1;
        endcase
        if (dec_illegal) begin
            dec_control = 8'h00;
            dec_use_imm = 1'b0;
            dec_use_pc  = 1'b0;
            dec_wb_en   = 1'b0;
            dec_branch  = 1'b0;
        end
    end

    // Output bundle register: flush beats pause beats accept
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid   <= 1'b0;
            out_control <= 8'h00;
            out_rs1     <= 5'd0;
            out_rs2     <= 5'd0;
            out_rd      <= 5'd0;
            out_imm     <= 32'd0;
            out_use_imm <= 1'b0;
            out_use_pc  <= 1'b0;
            out_wb_en   <= 1'b0;
            out_branch  <= 1'b0;
            out_illegal <= 1'b0;
            out_pc      <= 32'd0;
        end else if (flush) begin
            // Only the side-effecting bits are cleared; the rest may go stale
            out_valid  <= 1'b0;
            out_wb_en  <= 1'b0;
            out_branch <= 1'b0;
        end else if (!pause) begin
            if (in_valid) begin
                out_valid   <= 1'b1;
                out_control <= dec_control;
                out_rs1     <= dec_rs1;
                out_rs2     <= in_instr[24:20];
                out_rd      <= in_instr[11:7];
                out_imm     <= dec_imm;
                out_use_imm <= dec_use_imm;
                out_use_pc  <= dec_use_pc;
                out_wb_en   <= dec_wb_en;
                out_branch  <= dec_branch;
                out_illegal <= dec_illegal;
                out_pc      <= in_pc;
            end else begin
                out_valid  <= 1'b0;
                out_wb_en  <= 1'b0;
                out_branch <= 1'b0;
            end
        end
    end

    // Saturating count of accepted illegal instructions
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            illegal_count <= '0;
        end else if (accept && dec_illegal && illegal_count != '1) begin
            illegal_count <= illegal_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_decode_stage.sv
// Scoreboard bench for alu_decode_stage: expected bundles are queued as instructions are
// driven and compared when the stage presents them; counter and handshake checked each cycle.
module tb_alu_decode_stage;

    localparam int unsigned CNT_W = 2;

    typedef struct {
        logic [7:0]  ctrl;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [31:0] pc;
        logic        use_imm;
        logic        use_pc;
        logic        wb_en;
        logic        branch;
        logic        illegal;
        logic        chk_rs;
        logic        chk_rd;
        logic        chk_imm;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             pause;
    logic             flush;
    logic             in_valid;
    logic [31:0]      in_instr;
    logic [31:0]      in_pc;
    logic             in_ready;
    logic             out_valid;
    logic [7:0]       out_control;
    logic [4:0]       out_rs1;
    logic [4:0]       out_rs2;
    logic [4:0]       out_rd;
    logic [31:0]      out_imm;
    logic             out_use_imm;
    logic             out_use_pc;
    logic             out_wb_en;
    logic             out_branch;
    logic             out_illegal;
    logic [31:0]      out_pc;
    logic [CNT_W-1:0] illegal_count;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb[$];
    exp_t cur;
    logic exp_valid = 1'b0;
    int   exp_cnt   = 0;

    alu_decode_stage #(.CNT_W(CNT_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .pause         (pause),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_instr      (in_instr),
        .in_pc         (in_pc),
        .in_ready      (in_ready),
        .out_valid     (out_valid),
        .out_control   (out_control),
        .out_rs1       (out_rs1),
        .out_rs2       (out_rs2),
        .out_rd        (out_rd),
        .out_imm       (out_imm),
        .out_use_imm   (out_use_imm),
        .out_use_pc    (out_use_pc),
        .out_wb_en     (out_wb_en),
        .out_branch    (out_branch),
        .out_illegal   (out_illegal),
        .out_pc        (out_pc),
        .illegal_count (illegal_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    function automatic exp_t mk(input logic [7:0] ctrl, input logic [4:0] rs1, rs2, rd,
                                input logic [31:0] imm, pc, input logic use_imm, use_pc,
                                wb_en, branch, illegal, chk_rs, chk_rd, chk_imm);
        exp_t e;
        e.ctrl = ctrl; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.imm = imm; e.pc = pc;
        e.use_imm = use_imm; e.use_pc = use_pc; e.wb_en = wb_en; e.branch = branch;
        e.illegal = illegal; e.chk_rs = chk_rs; e.chk_rd = chk_rd; e.chk_imm = chk_imm;
        return e;
    endfunction

    // Expected bundle for an illegal instruction (no register/immediate expectations)
    function automatic exp_t mk_ill(input logic [31:0] pc);
        return mk(8'h00, 5'd0, 5'd0, 5'd0, 32'd0, pc, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                  1'b0, 1'b0, 1'b0);
    endfunction

    task automatic compare_outputs();
        check("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
        check("illegal_count", {30'd0, illegal_count}, exp_cnt);
        if (exp_valid) begin
            check("control", {24'd0, out_control}, {24'd0, cur.ctrl});
            check("use_imm", {31'd0, out_use_imm}, {31'd0, cur.use_imm});
            check("use_pc", {31'd0, out_use_pc}, {31'd0, cur.use_pc});
            check("wb_en", {31'd0, out_wb_en}, {31'd0, cur.wb_en});
            check("branch", {31'd0, out_branch}, {31'd0, cur.branch});
            check("illegal", {31'd0, out_illegal}, {31'd0, cur.illegal});
            check("pc", out_pc, cur.pc);
            if (cur.chk_rs) begin
                check("rs1", {27'd0, out_rs1}, {27'd0, cur.rs1});
                check("rs2", {27'd0, out_rs2}, {27'd0, cur.rs2});
            end
            if (cur.chk_rd) check("rd", {27'd0, out_rd}, {27'd0, cur.rd});
            if (cur.chk_imm) check("imm", out_imm, cur.imm);
        end else begin
            check("idle_wb_en", {31'd0, out_wb_en}, 32'd0);
            check("idle_branch", {31'd0, out_branch}, 32'd0);
        end
    endtask

    // One cycle of stimulus; queues the expectation if the stage should accept it
    task automatic drive(input logic v, input logic [31:0] instr, pc, input logic p, f,
                         input exp_t e);
        logic acc;
        logic nxt_valid;
        in_valid = v; in_instr = instr; in_pc = pc; pause = p; flush = f;
        #1;
        check("in_ready", {31'd0, in_ready}, {31'd0, ~p});
        acc = v & ~p & ~f;
        if (acc) sb.push_back(e);
        if (f)      nxt_valid = 1'b0;
        else if (p) nxt_valid = exp_valid;
        else        nxt_valid = acc;
        if (acc && e.illegal && exp_cnt < 3) exp_cnt++;
        @(posedge clk);
        #1;
        exp_valid = nxt_valid;
        if (acc && out_valid) begin
            check("sb_nonempty", sb.size(), (sb.size() > 0) ? sb.size() : 1);
            if (sb.size() > 0) cur = sb.pop_front();
        end
        compare_outputs();
    endtask

    task automatic idle();
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, mk_ill(32'd0));
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        #3;
        reset = 1'b1;
        exp_valid = 1'b0;
        exp_cnt   = 0;
        sb.delete();
    endtask

    initial begin
        exp_t e_dummy;
        reset = 1'b0; pause = 1'b0; flush = 1'b0;
        in_valid = 1'b0; in_instr = 32'd0; in_pc = 32'd0;
        e_dummy = mk_ill(32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_control", {24'd0, out_control}, 32'd0);
        check("rst_count", {30'd0, illegal_count}, 32'd0);
        reset = 1'b1;

        // sub x3,x1,x2
        drive(1'b1, 32'h402081b3, 32'h10, 1'b0, 1'b0,
              mk(8'h02, 5'd1, 5'd2, 5'd3, 32'd0, 32'h10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                 1'b1, 1'b1, 1'b0));
        // Asynchronous reset while out_valid=1, sampled before the next clock edge
        in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("areset_valid", {31'd0, out_valid}, 32'd0);
        check("areset_control", {24'd0, out_control}, 32'd0);
        check("areset_rs1", {27'd0, out_rs1}, 32'd0);
        check("areset_rd", {27'd0, out_rd}, 32'd0);
        check("areset_pc", out_pc, 32'd0);
        check("areset_wb_en", {31'd0, out_wb_en}, 32'd0);
        check("areset_imm", out_imm, 32'd0);
        #1;
        reset = 1'b1;
        exp_valid = 1'b0;
        sb.delete();

        // add x0,x1,x2
        drive(1'b1, 32'h00208033, 32'h14, 1'b0, 1'b0,
              mk(8'h01, 5'd1, 5'd2, 5'd0, 32'd0, 32'h14, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                 1'b1, 1'b1, 1'b0));
        // srai x5,x6,4
        drive(1'b1, 32'h40435293, 32'h18, 1'b0, 1'b0,
              mk(8'h0e, 5'd6, 5'd0, 5'd5, 32'd4, 32'h18, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0,
                 1'b0, 1'b1, 1'b1));
        check("srai_rs1", {27'd0, out_rs1}, 32'd6);
        // sltu x3,x1,x2
        drive(1'b1, 32'h0020b1b3, 32'h1c, 1'b0, 1'b0,
              mk(8'h0a, 5'd1, 5'd2, 5'd3, 32'd0, 32'h1c, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                 1'b1, 1'b1, 1'b0));
        idle();
        // bge x1,x2,-8
        drive(1'b1, 32'hfe20dce3, 32'h20, 1'b0, 1'b0,
              mk(8'h09, 5'd1, 5'd2, 5'd0, 32'hfffffff8, 32'h20, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                 1'b1, 1'b0, 1'b1));
        // lui x1,0x12345
        drive(1'b1, 32'h123450b7, 32'h24, 1'b0, 1'b0,
              mk(8'h01, 5'd0, 5'd0, 5'd1, 32'h12345000, 32'h24, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0,
                 1'b0, 1'b1, 1'b1));
        check("lui_rs1", {27'd0, out_rs1}, 32'd0);
        // auipc x7,0x1
        drive(1'b1, 32'h00001397, 32'h200, 1'b0, 1'b0,
              mk(8'h01, 5'd0, 5'd0, 5'd7, 32'h1000, 32'h200, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0,
                 1'b0, 1'b1, 1'b1));
        // or x4,x5,x6
        drive(1'b1, 32'h0062e233, 32'h204, 1'b0, 1'b0,
              mk(8'h04, 5'd5, 5'd6, 5'd4, 32'd0, 32'h204, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                 1'b1, 1'b1, 1'b0));

        // Pause three cycles with a different instruction offered: outputs hold the 'or'
        for (int i = 0; i < 3; i++) drive(1'b1, 32'h402081b3, 32'h300, 1'b1, 1'b0, e_dummy);
        // Flush while paused invalidates the held bundle
        drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b1, e_dummy);
        // Flush with a valid instruction drops it
        drive(1'b1, 32'h0020b1b3, 32'h304, 1'b0, 1'b1, e_dummy);
        // beq x1,x2 style: blt x1,x2 (funct3 100) via sltu slot reused for ordering
        drive(1'b1, 32'h0020c463, 32'h308, 1'b0, 1'b0,
              mk(8'h08, 5'd1, 5'd2, 5'd0, 32'h8, 32'h308, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                 1'b1, 1'b0, 1'b1));

        // slli with funct7=0100000 is illegal
        drive(1'b1, 32'h40109093, 32'h400, 1'b0, 1'b0, mk_ill(32'h400));
        // Flushed illegal instruction does not count
        drive(1'b1, 32'hffffffff, 32'h404, 1'b0, 1'b1, e_dummy);
        // Paused illegal instruction does not count either
        drive(1'b1, 32'hffffffff, 32'h408, 1'b1, 1'b0, e_dummy);

        // Saturation from a clean counter: 1,2,3,3,3
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'hffffffff, 32'h500 + 4 * i, 1'b0, 1'b0, mk_ill(32'h500 + 4 * i));
        end
        idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
